// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Initiator side of the unified instruction/data word memory. Two clients,
// instruction fetch (read-only) and data (read/write), are arbitrated
// round-robin. One access runs at a time: IDLE -> ACCESS (ACCESS_CYCLES
// cycles with one enable held) -> RESP (one-cycle done pulse) -> IDLE.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   if_req, if_addr          fetch request (level) and address
//   if_gnt, if_done          fetch accepted / fetch data valid on rdata (pulses)
//   d_req, d_we, d_addr,     data request (level), direction, address,
//   d_wdata                  write value
//   d_gnt, d_done            data accepted / data access complete (pulses)
//   rdata                    last read result, held until the next read
//   mem_read, mem_write,     memory enables, address and write data
//   address, write_data
//   read_data                memory read data, combinational from address
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W        = 13,
    parameter int DATA_W        = 16,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    // Wait counter counts down from ACCESS_CYCLES-1 to 0; keep it at least 1 bit.
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            state_r;
    logic              owner_fetch_r;   // 1: fetch owns the access in flight
    logic              rr_fetch_r;      // 1: fetch wins the next tie
    logic [CNT_W-1:0]  cnt_r;
    logic              if_gnt_r;
    logic              d_gnt_r;
    logic              if_done_r;
    logic              d_done_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic [ADDR_W-1:0] address_r;
    logic [DATA_W-1:0] write_data_r;
    logic [DATA_W-1:0] rdata_r;

    logic              any_req_s;
    logic              pick_fetch_s;

    // Arbitration decision: a lone requester wins, a tie goes where the pointer says.
    always_comb begin
        any_req_s    = if_req | d_req;
        pick_fetch_s = 1'b0;
        if (if_req && d_req) begin
            pick_fetch_s = rr_fetch_r;
        end else if (if_req) begin
            pick_fetch_s = 1'b1;
        end else begin
            pick_fetch_s = 1'b0;
        end
    end

    // Access sequencer: state, latched request, enables, pulses and read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            owner_fetch_r <= 1'b0;
            rr_fetch_r    <= 1'b1;
            cnt_r         <= CNT_ZERO;
            if_gnt_r      <= 1'b0;
            d_gnt_r       <= 1'b0;
            if_done_r     <= 1'b0;
            d_done_r      <= 1'b0;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            address_r     <= {ADDR_W{1'b0}};
            write_data_r  <= {DATA_W{1'b0}};
            rdata_r       <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        state_r       <= ST_ACCESS;
                        owner_fetch_r <= pick_fetch_s;
                        rr_fetch_r    <= ~pick_fetch_s;
                        cnt_r         <= CNT_LOAD;
                        if_gnt_r      <= pick_fetch_s;
                        d_gnt_r       <= ~pick_fetch_s;
                        if (pick_fetch_s) begin
                            // Fetch is always a read; write_data keeps its last value.
                            mem_read_r  <= 1'b1;
                            mem_write_r <= 1'b0;
                            address_r   <= if_addr;
                        end else begin
                            mem_read_r   <= ~d_we;
                            mem_write_r  <= d_we;
                            address_r    <= d_addr;
                            write_data_r <= d_wdata;
                        end
                    end else begin
                        state_r  <= ST_IDLE;
                        if_gnt_r <= 1'b0;
                        d_gnt_r  <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    // Grant is a single pulse on the first access cycle.
                    if_gnt_r <= 1'b0;
                    d_gnt_r  <= 1'b0;
                    if (cnt_r == CNT_ZERO) begin
                        if (mem_read_r) begin
                            rdata_r <= read_data;
                        end else begin
                            rdata_r <= rdata_r;
                        end
                        mem_read_r  <= 1'b0;
                        mem_write_r <= 1'b0;
                        if_done_r   <= owner_fetch_r;
                        d_done_r    <= ~owner_fetch_r;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if_done_r <= 1'b0;
                    d_done_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    if_gnt_r    <= 1'b0;
                    d_gnt_r     <= 1'b0;
                    if_done_r   <= 1'b0;
                    d_done_r    <= 1'b0;
                    mem_read_r  <= 1'b0;
                    mem_write_r <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt     = if_gnt_r;
    assign d_gnt      = d_gnt_r;
    assign if_done    = if_done_r;
    assign d_done     = d_done_r;
    assign mem_read   = mem_read_r;
    assign mem_write  = mem_write_r;
    assign address    = address_r;
    assign write_data = write_data_r;
    assign rdata      = rdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// Bench for mem_access_ctrl: instance 0 runs with ACCESS_CYCLES=1, instance 1
// with ACCESS_CYCLES=3. Each has its own word memory model. Expected accesses
// are queued when requests are driven and compared when gnt/done appear.
module tb_mem_access_ctrl;

    localparam int AW = 13;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        [2];
    logic          if_req     [2];
    logic [AW-1:0] if_addr    [2];
    logic          if_gnt     [2];
    logic          if_done    [2];
    logic          d_req      [2];
    logic          d_we       [2];
    logic [AW-1:0] d_addr     [2];
    logic [DW-1:0] d_wdata    [2];
    logic          d_gnt      [2];
    logic          d_done     [2];
    logic [DW-1:0] rdata      [2];
    logic          mem_read   [2];
    logic          mem_write  [2];
    logic [AW-1:0] address    [2];
    logic [DW-1:0] write_data [2];
    logic [DW-1:0] read_data  [2];

    logic [DW-1:0] mem     [2][8192];
    logic [DW-1:0] ref_mem [2][8192];
    logic [DW-1:0] last_rd [2];

    typedef struct {
        int            inst;
        logic          fetch;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   gnt_cyc  [2];
    int   en_cnt   [2];

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]), .if_done(if_done[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_gnt(d_gnt[0]), .d_done(d_done[0]), .rdata(rdata[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .address(address[0]),
        .write_data(write_data[0]), .read_data(read_data[0])
    );

    mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]), .if_done(if_done[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_gnt(d_gnt[1]), .d_done(d_done[1]), .rdata(rdata[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .address(address[1]),
        .write_data(write_data[1]), .read_data(read_data[1])
    );

    // Memory models: combinational read, write on the rising edge.
    assign read_data[0] = mem_read[0] ? mem[0][address[0]] : 16'h0000;
    assign read_data[1] = mem_read[1] ? mem[1][address[1]] : 16'h0000;

    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mem_write[k]) mem[k][address[k]] = write_data[k];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int ac_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] outs(input int k);
        return {13'd0, if_gnt[k], if_done[k], d_gnt[k], d_done[k], mem_read[k], mem_write[k],
                address[k], write_data[k], rdata[k]};
    endfunction

    // Monitor: compares gnt/done events of both instances against the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (if_gnt[k] || d_gnt[k]) begin
                    check_eq("gnt_excl", 64'(if_gnt[k] & d_gnt[k]), 64'd0);
                    if (exp_q.size() == 0 || exp_q[0].inst != k) begin
                        check_eq("gnt_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q[0];
                        check_eq("gnt_owner", 64'(if_gnt[k]), 64'(e.fetch));
                        check_eq("gnt_en", 64'({mem_read[k], mem_write[k]}), 64'({~e.we, e.we}));
                        check_eq("gnt_addr", 64'(address[k]), 64'(e.addr));
                        if (e.we) check_eq("gnt_wdata", 64'(write_data[k]), 64'(e.wdata));
                    end
                    gnt_cyc[k] = cyc;
                    en_cnt[k]  = 0;
                end
                if (mem_read[k] || mem_write[k]) begin
                    check_eq("en_excl", 64'(mem_read[k] & mem_write[k]), 64'd0);
                    en_cnt[k]++;
                end
                if (if_done[k] || d_done[k]) begin
                    check_eq("done_excl", 64'(if_done[k] & d_done[k]), 64'd0);
                    if (exp_q.size() == 0 || exp_q[0].inst != k) begin
                        check_eq("done_unexpected", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("done_owner", 64'(if_done[k]), 64'(e.fetch));
                        check_eq("done_rdata", 64'(rdata[k]), 64'(e.rdata));
                        check_eq("en_cycles", 64'(en_cnt[k]), 64'(ac_of(k)));
                        check_eq("done_latency", 64'(cyc - gnt_cyc[k]), 64'(ac_of(k)));
                    end
                end
            end
        end
    end

    // Queue the expected result of one access and its reference effect.
    function automatic void push_exp(input int k, input logic fetch, input logic we,
                                     input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        exp_t e;
        e.inst  = k;
        e.fetch = fetch;
        e.we    = fetch ? 1'b0 : we;
        e.addr  = addr;
        e.wdata = wd;
        if (e.we) begin
            ref_mem[k][addr] = wd;
            e.rdata = last_rd[k];
        end else begin
            e.rdata    = ref_mem[k][addr];
            last_rd[k] = e.rdata;
        end
        exp_q.push_back(e);
    endfunction

    task automatic issue(input int k, input logic fetch, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int exp_lat);
        int   lat;
        logic got;
        push_exp(k, fetch, we, addr, wd);
        @(negedge clk);
        if (fetch) begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end else begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            got = fetch ? if_gnt[k] : d_gnt[k];
        end
        if_req[k] = 1'b0;
        d_req[k]  = 1'b0;
        check_eq("gnt_latency", 64'(lat), 64'(exp_lat));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Both clients request continuously; grants must alternate starting with fetch.
    task automatic arb(input int k, input int n, input logic [AW-1:0] fa, input logic [AW-1:0] da);
        int cnt;
        int t;
        for (int i = 0; i < n; i++) push_exp(k, (i % 2) == 0, 1'b0, ((i % 2) == 0) ? fa : da, 16'h0000);
        @(negedge clk);
        if_req[k] = 1'b1; if_addr[k] = fa;
        d_req[k]  = 1'b1; d_we[k] = 1'b0; d_addr[k] = da;
        cnt = 0;
        t   = 0;
        while (cnt < n && t < 60) begin
            @(posedge clk); #1;
            t++;
            if (if_gnt[k] || d_gnt[k]) cnt++;
        end
        if_req[k] = 1'b0;
        d_req[k]  = 1'b0;
        check_eq("arb_grants", 64'(cnt), 64'(n));
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   lat;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = '0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
            last_rd[k] = 16'h0000; gnt_cyc[k] = 0; en_cnt[k] = 0;
        end
        mem[0][500] = 16'd2; ref_mem[0][500] = 16'd2;
        mem[1][506] = 16'd3; ref_mem[1][506] = 16'd3;

        // Reset, then five idle cycles with everything at 0.
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("rst_outs_a", outs(0), 64'd0);
            check_eq("rst_outs_b", outs(1), 64'd0);
        end

        // ACCESS_CYCLES=1: fetch, write, read back, then round-robin.
        issue(0, 1'b1, 1'b0, 13'd500, 16'h0000, 1);
        drain();
        issue(0, 1'b0, 1'b1, 13'd600, 16'h00A7, 1);
        drain();
        issue(0, 1'b0, 1'b0, 13'd600, 16'h0000, 1);
        drain();
        arb(0, 4, 13'd500, 13'd600);

        // ACCESS_CYCLES=3: read with wait states.
        issue(1, 1'b1, 1'b0, 13'd506, 16'h0000, 1);
        drain();

        // Reset in the second cycle of a write: the access is abandoned.
        e.inst = 1; e.fetch = 1'b0; e.we = 1'b1; e.addr = 13'd700; e.wdata = 16'h5A5A; e.rdata = last_rd[1];
        exp_q.push_back(e);
        @(negedge clk);
        d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 13'd700; d_wdata[1] = 16'h5A5A;
        lat = 0;
        while (!d_gnt[1] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d_req[1] = 1'b0;
        check_eq("rstmid_gnt_latency", 64'(lat), 64'd1);
        @(posedge clk); #1;
        check_eq("rstmid_write_2nd", 64'(mem_write[1]), 64'd1);
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        exp_q.delete();
        last_rd[1] = 16'h0000;
        check_eq("rstmid_write_low", 64'(mem_write[1]), 64'd0);
        check_eq("rstmid_outs", outs(1), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check_eq("rstmid_quiet", outs(1), 64'd0);

        // After reset the pointer favours fetch again; then a plain read.
        arb(1, 2, 13'd506, 13'd506);
        issue(1, 1'b1, 1'b0, 13'd506, 16'h0000, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the 16-bit word memory interface: mem_read, mem_write, address, write_data, read_data.
- Accepts requests from two datapath clients: instruction fetch (read-only) and data (read/write).
- Arbitrates between them round-robin, sequences one memory access at a time, and returns read data with a completion pulse.
- Sits between the multi-cycle control/datapath and the unified instruction/data memory.

Parameters:
ADDR_W, 13, address width (word-addressed)
DATA_W, 16, data word width
ACCESS_CYCLES, 1, cycles mem_read/mem_write held per access (>=1; wait states for slower memories)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
if_req  input  1  fetch request, level; held until if_gnt
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  one-cycle pulse: fetch request accepted
if_done  output  1  one-cycle pulse: fetch data valid on rdata
d_req  input  1  data request, level; held until d_gnt
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  data write value
d_gnt  output  1  one-cycle pulse: data request accepted
d_done  output  1  one-cycle pulse: data access complete
rdata  output  DATA_W  last read result, registered
mem_read  output  1  memory read enable
mem_write  output  1  memory write enable
address  output  ADDR_W  memory address
write_data  output  DATA_W  memory write data
read_data  input  DATA_W  memory read data, combinational from address/mem_read

Behaviour:
- Reset (synchronous, active-high):
  - State IDLE.
  - All outputs 0: gnt, done, mem_read, mem_write, address, write_data, rdata.
  - Round-robin pointer favours fetch.
- Reset mid-access: enables drop on the next cycle; no done is issued; the pending request is discarded. Clients must re-request.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If either req is high at the edge: latch owner, address, we (fetch forces we=0) and wdata. Load the wait counter with ACCESS_CYCLES-1, go to ACCESS, and assert the owner's gnt for the first ACCESS cycle only.
  - Both requesting: grant the client the pointer favours, then point the pointer at the other client.
  - Single requester: grant it; the pointer points away from it.
- ACCESS:
  - address and write_data are driven from the latched values.
  - Exactly one of mem_read or mem_write is high for ACCESS_CYCLES consecutive cycles.
  - The counter decrements each cycle. On the cycle it is 0:
    - Read: rdata <= read_data at the edge.
    - Write: rdata is unchanged.
    - Then go to RESP.
  - Requests arriving during ACCESS are ignored and must remain asserted.
- RESP:
  - Enables are 0; the owner's done is high for one cycle.
  - Next cycle the block is back in IDLE and may accept a new request.
  - rdata holds its value until the next read completes.
- Timing:
  - With req sampled at edge N: gnt and the enable are high in cycle N+1, done is high in cycle N+1+ACCESS_CYCLES.
  - One access per ACCESS_CYCLES+2 cycles.
- Client rules: deassert req in the cycle gnt is seen; address, we and wdata need only be valid when req is sampled. A req still high in the IDLE cycle after done is treated as a new request.
- Outputs outside ACCESS: mem_read = mem_write = 0; address and write_data hold their last driven values.
- Never: gnt or done to both clients in the same cycle; mem_read and mem_write high together.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, no gnt or done.
- Memory word 500 = 2; if_req with if_addr=500 sampled at edge N:
  - if_gnt and mem_read high in cycle N+1 with address=500.
  - if_done high in cycle N+2 with rdata=2.
- d_req, d_we=1, d_addr=600, d_wdata=16'h00A7:
  - One mem_write cycle with address=600, write_data=16'h00A7; d_done follows; rdata unchanged.
  - Then a d_req read of 600 -> rdata=16'h00A7.
- if_req and d_req both held continuously for 4 grants -> grants alternate fetch, data, fetch, data (fetch first after reset); never two gnts in one cycle.
- ACCESS_CYCLES=3, read of 506 (value 3) -> mem_read high exactly 3 cycles; if_done 4 cycles after the request is sampled; rdata=3.
- Assert rst in the second cycle of a write with ACCESS_CYCLES=3 -> mem_write low the next cycle, no d_done, state IDLE, all outputs 0.
